spi_master: RTL and testbench

Command-issuing master for the SPI slave + single-port RAM subsystem. It accepts 10-bit command words from a host-side valid/ready port and serializes them MSB first on MOSI under SS_n. For read-data commands it then collects the 8-bit RAM byte returned on MISO and presents it on a response port. It is the bus-side driver used both as synthesizable host logic and as the active agent for end-to-end checks of the slave.

---
 rtl/spi_master.sv | 172 +++++++++++++++++
 tb/tb_spi_master.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: serializes 10-bit command words MSB first on MOSI under SS_n and,
// for read-data commands, collects the 8-bit byte returned on MISO.
// Handshake: a word is taken on the rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, so req_valid while busy is simply ignored and
// req_data is captured once, at that edge.
module spi_master #(
    parameter int RD_WAIT    = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [9:0] req_data,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_OUT = 3'd1,
        WAIT_RD   = 3'd2,
        SHIFT_IN  = 3'd3,
        GAP       = 3'd4
    } state_t;

    // The edge that ends the last MOSI bit already counts as the first wait
    // cycle, so WAIT_RD itself lasts RD_WAIT-1 cycles (skipped when RD_WAIT=1).
    localparam logic [3:0] RD_LOAD = (RD_WAIT > 1) ? 4'(RD_WAIT - 2) : 4'd0;
    // After a read the full GAP_CYCLES are spent in GAP; after a non-read frame
    // the IDLE cycle before the next accept is itself one of the high cycles.
    localparam logic [3:0] GAP_RD_LOAD = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] GAP_WR_LOAD = (GAP_CYCLES > 1) ? 4'(GAP_CYCLES - 2) : 4'd0;

    state_t      state_q, state_d;
    logic [9:0]  tx_q, tx_d;
    // Only seven bits are held: the eighth sample goes straight into rsp_data.
    logic [6:0]  rx_q, rx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_rd_q, is_rd_d;
    logic        ss_n_q, ss_n_d;
    logic        mosi_q, mosi_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign dbg_state = state_q;

    // Next-state and next-output decode for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cnt_d       = cnt_q;
        is_rd_d     = is_rd_q;
        ss_n_d      = ss_n_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                ss_n_d = 1'b1;
                mosi_d = 1'b0;
                if (req_valid) begin
                    tx_d    = req_data;
                    is_rd_d = (req_data[9:8] == 2'b11);
                    ss_n_d  = 1'b0;
                    mosi_d  = req_data[9];
                    cnt_d   = 4'd9;
                    state_d = SHIFT_OUT;
                end
            end
            SHIFT_OUT: begin
                if (cnt_q == 4'd0) begin
                    mosi_d = 1'b0;
                    if (is_rd_q) begin
                        if (RD_WAIT == 1) begin
                            cnt_d   = 4'd7;
                            state_d = SHIFT_IN;
                        end else begin
                            cnt_d   = RD_LOAD;
                            state_d = WAIT_RD;
                        end
                    end else begin
                        ss_n_d = 1'b1;
                        if (GAP_CYCLES == 1) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d   = GAP_WR_LOAD;
                            state_d = GAP;
                        end
                    end
                end else begin
                    // tx_q[8] is the next bit once the current MSB is consumed.
                    tx_d   = tx_q << 1;
                    mosi_d = tx_q[8];
                    cnt_d  = cnt_q - 4'd1;
                end
            end
            WAIT_RD: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = 4'd7;
                    state_d = SHIFT_IN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SHIFT_IN: begin
                rx_d = {rx_q[5:0], MISO};
                if (cnt_q == 4'd0) begin
                    rsp_data_d  = {rx_q, MISO};
                    rsp_valid_d = 1'b1;
                    ss_n_d      = 1'b1;
                    cnt_d       = GAP_RD_LOAD;
                    state_d     = GAP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            GAP: begin
                ss_n_d = 1'b1;
                mosi_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                ss_n_d  = 1'b1;
                mosi_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any frame in flight at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_q        <= 10'd0;
            rx_q        <= 7'd0;
            cnt_q       <= 4'd0;
            is_rd_q     <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cnt_q       <= cnt_d;
            is_rd_q     <= is_rd_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: random and directed command streams against spi_master with a
// bus-side slave+RAM model; frames and read bytes are scoreboarded.
module tb_spi_master;
  localparam int RD_WAIT    = 2;
  localparam int GAP_CYCLES = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [9:0] req_data = 10'd0;
  logic       miso = 1'b0;
  logic       req_ready, rsp_valid, busy, ss_n, mosi;
  logic [7:0] rsp_data;
  logic [2:0] dbg_state;

  int checks = 0;
  int failures = 0;

  logic [9:0] exp_q[$];
  logic [7:0] exp_rsp_q[$];
  int         gaps[$];

  // reference model (host view) and slave model (bus view)
  logic [7:0] mem_r[256];
  logic [7:0] mem_s[256];
  logic [7:0] wa_r = 8'd0, ra_r = 8'd0;
  logic [7:0] wa_s = 8'd0, ra_s = 8'd0, rd_byte_s = 8'd0;
  logic [7:0] rsp_hold = 8'h00;

  int   frames_seen = 0;
  bit   mosi_bad = 1'b0;
  bit   busy_bad = 1'b0;
  int   low_cnt = 0;
  int   high_cnt = 0;
  int   rsp_run = 0;
  bit   in_frame = 1'b0;
  logic [9:0] rx_word = 10'd0;

  spi_master #(.RD_WAIT(RD_WAIT), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (ss_n),
    .MOSI      (mosi),
    .MISO      (miso),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=absent required=present", name);
  endtask

  function automatic int ready_lat(input logic [9:0] w);
    return (w[9:8] == 2'b11) ? 17 + RD_WAIT + GAP_CYCLES : 9 + GAP_CYCLES;
  endfunction

  // driver: called on a negedge; returns on the negedge after the accepting edge
  task automatic send(input logic [9:0] w);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_data  = w;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      fail("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back(w);
    case (w[9:8])
      2'b00: wa_r = w[7:0];
      2'b01: mem_r[wa_r] = w[7:0];
      2'b10: ra_r = w[7:0];
      default: exp_rsp_q.push_back(mem_r[ra_r]);
    endcase
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int exp_n);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, n, exp_n);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  // monitor + slave/RAM model + scoreboard, all on the negedge
  always @(negedge clk) begin : mon
    int j;
    logic [9:0] ew;
    logic [7:0] er;
    if (!rst_n) begin
      low_cnt  = 0;
      high_cnt = 0;
      in_frame = 1'b0;
      rsp_run  = 0;
      miso     = 1'b0;
    end else begin
      if (busy !== !req_ready) busy_bad = 1'b1;
      if (rsp_valid === 1'b1) begin
        rsp_run++;
        check("rsp_single_pulse", rsp_run, 1);
        check("rsp_at_frame_end", {30'd0, ss_n, in_frame}, 32'd3);
        if (exp_rsp_q.size() == 0) fail("rsp_expected");
        else begin
          er = exp_rsp_q.pop_front();
          check("rsp_data", rsp_data, er);
          rsp_hold = er;
        end
      end else begin
        rsp_run = 0;
      end
      if (ss_n === 1'b0) begin
        if (!in_frame) begin
          gaps.push_back(high_cnt);
          in_frame = 1'b1;
          low_cnt  = 0;
        end
        j = low_cnt;
        if (j < 10) rx_word[9-j] = mosi;
        else if (mosi !== 1'b0) mosi_bad = 1'b1;
        if (j == 9) begin
          case (rx_word[9:8])
            2'b00: wa_s = rx_word[7:0];
            2'b01: mem_s[wa_s] = rx_word[7:0];
            2'b10: ra_s = rx_word[7:0];
            default: rd_byte_s = mem_s[ra_s];
          endcase
        end
        if (rx_word[9:8] == 2'b11 && j >= 9 + RD_WAIT && j <= 16 + RD_WAIT)
          miso = rd_byte_s[7-(j-9-RD_WAIT)];
        else
          miso = 1'($urandom_range(0, 1));
        low_cnt++;
      end else begin
        if (in_frame) begin
          frames_seen++;
          if (exp_q.size() == 0) fail("frame_expected");
          else begin
            ew = exp_q.pop_front();
            check("frame_word", rx_word, ew);
            check("frame_len", low_cnt, (ew[9:8] == 2'b11) ? 17 + RD_WAIT : 10);
          end
          check("rsp_data_hold", rsp_data, rsp_hold);
          in_frame = 1'b0;
          high_cnt = 0;
        end
        if (mosi !== 1'b0) mosi_bad = 1'b1;
        high_cnt++;
        miso = 1'($urandom_range(0, 1));
      end
    end
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int f0;
    logic [7:0] v;
    logic [9:0] w;
    logic [7:0] addrs[3];
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      mem_r[i] = v;
      mem_s[i] = v;
    end
    addrs[0] = 8'h10;
    addrs[1] = 8'h00;
    addrs[2] = 8'hFF;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ss_n", ss_n, 1);
    check("rst_mosi", mosi, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // write-addr 0AB
    send(10'h0AB);
    wait_ready("wa_ready_lat", 9 + GAP_CYCLES);
    settle();

    // read-data returning 5A
    send(10'h020); wait_ready("setup_lat", 9 + GAP_CYCLES);
    send(10'h15A); wait_ready("setup_lat", 9 + GAP_CYCLES);
    send(10'h220); wait_ready("setup_lat", 9 + GAP_CYCLES);
    send(10'h300);
    wait_ready("rd_ready_lat", 17 + RD_WAIT + GAP_CYCLES);
    settle();
    check("rd_5a", rsp_data, 8'h5A);

    // back-to-back writes with req_valid held
    gaps.delete();
    f0 = frames_seen;
    send(10'h1FF);
    send(10'h100);
    send(10'h155);
    wait_ready("b2b_last_lat", 9 + GAP_CYCLES);
    settle();
    check("b2b_frames", frames_seen - f0, 3);
    if (gaps.size() >= 3) begin
      check("b2b_gap1", gaps[1], GAP_CYCLES);
      check("b2b_gap2", gaps[2], GAP_CYCLES);
    end else fail("b2b_gaps");

    // reset during bit 4 of a read-data frame
    send(10'h300);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ss_n", ss_n, 1);
    check("mid_rst_mosi", mosi, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_data", rsp_data, 8'h00);
    exp_q.delete();
    exp_rsp_q.delete();
    rsp_hold = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(10'h0AB);
    wait_ready("post_rst_lat", 9 + GAP_CYCLES);
    settle();
    check("post_rst_rsp_data", rsp_data, 8'h00);

    // req_data changes and req_valid pulses while busy
    f0 = frames_seen;
    send(10'h1A5);
    for (int i = 0; i < 8; i++) begin
      req_data  = 10'($urandom);
      req_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    req_valid = 1'b0;
    wait_ready("busy_ignore_lat", 9 + GAP_CYCLES - 8);
    settle();
    check("busy_ignore_frames", frames_seen - f0, 1);

    // end-to-end write then read back
    for (int k = 0; k < 3; k++) begin
      send({2'b00, addrs[k]}); wait_ready("e2e_lat", 9 + GAP_CYCLES);
      send(10'h13C);           wait_ready("e2e_lat", 9 + GAP_CYCLES);
      send({2'b10, addrs[k]}); wait_ready("e2e_lat", 9 + GAP_CYCLES);
      send(10'h300);           wait_ready("e2e_lat", 17 + RD_WAIT + GAP_CYCLES);
      settle();
      check("e2e_rsp", rsp_data, 8'h3C);
    end

    // random command stream
    for (int k = 0; k < 50; k++) begin
      w = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
      send(w);
      wait_ready("rand_ready_lat", ready_lat(w));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    settle();

    // final report
    check("exp_frames_left", exp_q.size(), 0);
    check("exp_rsp_left", exp_rsp_q.size(), 0);
    check("mosi_idle_zero", mosi_bad, 0);
    check("busy_decode", busy_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
